// File: rtl/mips150_lsu_align.sv
// Load/store alignment unit: issues byte-enabled memory accesses and aligns returned load data.
// Optional LSU_MISALIGN_TRAP_EN: suppress misaligned accesses and report them on exc_misalign/exc_addr.
module mips150_lsu_align #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [31:0]       wb_data,
    output logic              exc_misalign,
    output logic [ADDR_W-1:0] exc_addr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic             w_ld;
    logic             w_st;
    logic             w_sgn;
    logic [1:0]       w_size;
    logic [1:0]       w_off;
    logic [3:0]       w_we;
    logic [31:0]      w_wdata;
    logic             w_accept;
    logic             w_sup;
    logic             w_go;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_wb_data;

    logic              r_ready;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W-1:0]  r_wptr;
    logic              r_mem_en;
    logic [3:0]        r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_wb_valid;
    logic [RD_W-1:0]   r_wb_rd;
    logic [31:0]       r_wb_data;

    logic [RD_W-1:0]   r_q_rd   [DEPTH];
    logic [1:0]        r_q_size [DEPTH];
    logic              r_q_sgn  [DEPTH];
    logic [1:0]        r_q_off  [DEPTH];

    // Opcode decode, forced lane offset and store lane steering
    always_comb begin
        w_ld    = 1'b0;
        w_st    = 1'b0;
        w_sgn   = 1'b0;
        w_size  = SZ_W;
        w_off   = 2'b00;
        w_we    = 4'b0000;
        w_wdata = req_wdata;
        case (req_opcode)
            OP_LB:  begin w_ld = 1'b1; w_size = SZ_B; w_sgn = 1'b1; end
            OP_LH:  begin w_ld = 1'b1; w_size = SZ_H; w_sgn = 1'b1; end
            OP_LW:  begin w_ld = 1'b1; w_size = SZ_W; end
            OP_LBU: begin w_ld = 1'b1; w_size = SZ_B; end
            OP_LHU: begin w_ld = 1'b1; w_size = SZ_H; end
            OP_SB:  begin w_st = 1'b1; w_size = SZ_B; end
            OP_SH:  begin w_st = 1'b1; w_size = SZ_H; end
            OP_SW:  begin w_st = 1'b1; w_size = SZ_W; end
            default: ;
        endcase
        case (w_size)
            SZ_B: begin
                w_off   = req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
                if (w_st) w_we = 4'b0001 << w_off;
            end
            SZ_H: begin
                w_off   = {req_addr[1], 1'b0};
                w_wdata = {2{req_wdata[15:0]}};
                if (w_st) w_we = 4'b0011 << w_off;
            end
            default: begin
                w_off = 2'b00;
                if (w_st) w_we = 4'b1111;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic              w_mis;
    logic              r_exc;
    logic [ADDR_W-1:0] r_exc_addr;

    assign w_mis = (w_ld | w_st) &&
                   (((w_size == SZ_H) && req_addr[0]) ||
                    ((w_size == SZ_W) && (req_addr[1:0] != 2'b00)));
    assign w_sup = w_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc      <= 1'b0;
            r_exc_addr <= '0;
        end else begin
            r_exc <= w_accept && w_mis;
            if (w_accept && w_mis) r_exc_addr <= req_addr;
        end
    end

    assign exc_misalign = r_exc;
    assign exc_addr     = r_exc_addr;
`else
    assign w_sup        = 1'b0;
    assign exc_misalign = 1'b0;
    assign exc_addr     = '0;
`endif

    assign w_accept = req_valid && r_ready;
    assign w_go     = w_accept && (w_ld | w_st) && !w_sup;
    assign w_push   = w_go && w_ld;
    assign w_pop    = mem_rvalid && (r_count != '0);

    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
            2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
            default: w_cnt_nxt = r_count;
        endcase
    end

    // Extract and extend the returned data for the FIFO head
    always_comb begin
        w_byte    = 8'h00;
        w_half    = r_q_off[r_rptr][1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_wb_data = mem_rdata;
        case (r_q_off[r_rptr])
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        case (r_q_size[r_rptr])
            SZ_B: w_wb_data = {{24{r_q_sgn[r_rptr] & w_byte[7]}}, w_byte};
            SZ_H: w_wb_data = {{16{r_q_sgn[r_rptr] & w_half[15]}}, w_half};
            default: w_wb_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready     <= 1'b0;
            r_count     <= '0;
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
        end else begin
            r_ready  <= (w_cnt_nxt < CNT_W'(DEPTH));
            r_count  <= w_cnt_nxt;
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_mem_en <= w_go;
            r_mem_we <= w_go ? w_we : 4'b0000;
            if (w_go) begin
                r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                r_mem_wdata <= w_wdata;
            end
            r_wb_valid <= w_pop;
            if (w_pop) begin
                r_wb_rd   <= r_q_rd[r_rptr];
                r_wb_data <= w_wb_data;
            end
        end
    end

    // Load metadata storage; contents are qualified by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_wptr]   <= req_rd;
            r_q_size[r_wptr] <= w_size;
            r_q_sgn[r_wptr]  <= w_sgn;
            r_q_off[r_wptr]  <= w_off;
        end
    end

    assign req_ready = r_ready;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;

endmodule
